// File: rtl/rs_station_if.sv
// Issue, common-data-bus and ALU dispatch signals of the ALU reservation station.
// The slave side is the station; the master side is the surrounding core (or a bench).
interface rs_station_if #(
  parameter int ROB_BIT  = 5,
  parameter int OP_WIDTH = 6
);
  logic                issue_valid;
  logic [OP_WIDTH-1:0] issue_op;
  logic [31:0]         issue_vj;
  logic [31:0]         issue_vk;
  logic [31:0]         issue_imm;
  logic                issue_qj_busy;
  logic                issue_qk_busy;
  logic [ROB_BIT-1:0]  issue_qj;
  logic [ROB_BIT-1:0]  issue_qk;
  logic [ROB_BIT-1:0]  issue_rob_id;
  logic                full;

  logic                alu_cdb_valid;
  logic [ROB_BIT-1:0]  alu_cdb_rob_id;
  logic [31:0]         alu_cdb_value;
  logic                lsb_cdb_valid;
  logic [ROB_BIT-1:0]  lsb_cdb_rob_id;
  logic [31:0]         lsb_cdb_value;

  logic                alu_valid;
  logic [OP_WIDTH-1:0] alu_op;
  logic [31:0]         alu_v1;
  logic [31:0]         alu_v2;
  logic [31:0]         alu_imm;
  logic [ROB_BIT-1:0]  alu_rob_id;

  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_vk, issue_imm,
    input  issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_rob_id,
    input  alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
    input  lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
    output full, alu_valid, alu_op, alu_v1, alu_v2, alu_imm, alu_rob_id
  );

  modport master (
    output issue_valid, issue_op, issue_vj, issue_vk, issue_imm,
    output issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_rob_id,
    output alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
    output lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
    input  full, alu_valid, alu_op, alu_v1, alu_v2, alu_imm, alu_rob_id
  );
endinterface

// File: rtl/rs_station.sv
// ALU reservation station: issue into the lowest free entry, CDB wakeup, lowest-index dispatch.
// Optional macro RS_ISSUE_FWD_EN: operands issued busy capture a same-cycle CDB broadcast.
module rs_station #(
  parameter int RS_SIZE  = 16,
  parameter int RS_BIT   = 4,
  parameter int ROB_BIT  = 5,
  parameter int OP_WIDTH = 6
) (
  input logic         clk_in,
  input logic         rst_in,
  input logic         rdy_in,
  input logic         flush_in,
  rs_station_if.slave bus
);

  logic [RS_SIZE-1:0]  busy;
  logic [RS_SIZE-1:0]  qj_busy;
  logic [RS_SIZE-1:0]  qk_busy;
  logic [OP_WIDTH-1:0] op     [RS_SIZE];
  logic [31:0]         vj     [RS_SIZE];
  logic [31:0]         vk     [RS_SIZE];
  logic [31:0]         imm    [RS_SIZE];
  logic [ROB_BIT-1:0]  qj     [RS_SIZE];
  logic [ROB_BIT-1:0]  qk     [RS_SIZE];
  logic [ROB_BIT-1:0]  rob_id [RS_SIZE];

  logic [RS_SIZE-1:0] prepared;
  logic [RS_BIT-1:0]  free_idx;
  logic [RS_BIT-1:0]  ready_idx;
  logic               free_found;
  logic               ready_found;
  logic [31:0]        new_vj;
  logic [31:0]        new_vk;
  logic               new_qj_busy;
  logic               new_qk_busy;

  assign prepared = busy & ~qj_busy & ~qk_busy;
  assign bus.full = &busy;

  // Scanning downwards leaves the lowest matching index selected.
  always_comb begin
    free_idx    = '0;
    free_found  = 1'b0;
    ready_idx   = '0;
    ready_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx   = RS_BIT'(i);
        free_found = 1'b1;
      end
      if (prepared[i]) begin
        ready_idx   = RS_BIT'(i);
        ready_found = 1'b1;
      end
    end
  end

  always_comb begin
    new_vj      = bus.issue_vj;
    new_vk      = bus.issue_vk;
    new_qj_busy = bus.issue_qj_busy;
    new_qk_busy = bus.issue_qk_busy;
`ifdef RS_ISSUE_FWD_EN
    if (bus.issue_qj_busy) begin
      if (bus.alu_cdb_valid && bus.alu_cdb_rob_id == bus.issue_qj) begin
        new_vj      = bus.alu_cdb_value;
        new_qj_busy = 1'b0;
      end else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_id == bus.issue_qj) begin
        new_vj      = bus.lsb_cdb_value;
        new_qj_busy = 1'b0;
      end
    end
    if (bus.issue_qk_busy) begin
      if (bus.alu_cdb_valid && bus.alu_cdb_rob_id == bus.issue_qk) begin
        new_vk      = bus.alu_cdb_value;
        new_qk_busy = 1'b0;
      end else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_id == bus.issue_qk) begin
        new_vk      = bus.lsb_cdb_value;
        new_qk_busy = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy    <= '0;
      qj_busy <= '0;
      qk_busy <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op[i]     <= '0;
        vj[i]     <= '0;
        vk[i]     <= '0;
        imm[i]    <= '0;
        qj[i]     <= '0;
        qk[i]     <= '0;
        rob_id[i] <= '0;
      end
      bus.alu_valid  <= 1'b0;
      bus.alu_op     <= '0;
      bus.alu_v1     <= '0;
      bus.alu_v2     <= '0;
      bus.alu_imm    <= '0;
      bus.alu_rob_id <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        busy          <= '0;
        bus.alu_valid <= 1'b0;
      end else begin
        if (ready_found) begin
          bus.alu_valid   <= 1'b1;
          bus.alu_op      <= op[ready_idx];
          bus.alu_v1      <= vj[ready_idx];
          bus.alu_v2      <= vk[ready_idx];
          bus.alu_imm     <= imm[ready_idx];
          bus.alu_rob_id  <= rob_id[ready_idx];
          busy[ready_idx] <= 1'b0;
        end else begin
          bus.alu_valid <= 1'b0;
        end

        // The ALU bus wins when both buses carry the awaited tag.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && qj_busy[i]) begin
            if (bus.alu_cdb_valid && bus.alu_cdb_rob_id == qj[i]) begin
              vj[i]      <= bus.alu_cdb_value;
              qj_busy[i] <= 1'b0;
            end else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_id == qj[i]) begin
              vj[i]      <= bus.lsb_cdb_value;
              qj_busy[i] <= 1'b0;
            end
          end
          if (busy[i] && qk_busy[i]) begin
            if (bus.alu_cdb_valid && bus.alu_cdb_rob_id == qk[i]) begin
              vk[i]      <= bus.alu_cdb_value;
              qk_busy[i] <= 1'b0;
            end else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_id == qk[i]) begin
              vk[i]      <= bus.lsb_cdb_value;
              qk_busy[i] <= 1'b0;
            end
          end
        end

        if (bus.issue_valid && free_found) begin
          busy[free_idx]    <= 1'b1;
          op[free_idx]      <= bus.issue_op;
          vj[free_idx]      <= new_vj;
          vk[free_idx]      <= new_vk;
          imm[free_idx]     <= bus.issue_imm;
          qj_busy[free_idx] <= new_qj_busy;
          qk_busy[free_idx] <= new_qk_busy;
          qj[free_idx]      <= bus.issue_qj;
          qk[free_idx]      <= bus.issue_qk;
          rob_id[free_idx]  <= bus.issue_rob_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: directed vector table, hand-written corner sequences and a random run
// compared every cycle against an entry-list reference model.
module tb_rs_station;
  localparam int RS_SIZE  = 16;
  localparam int ROB_BIT  = 5;
  localparam int OP_WIDTH = 6;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_in;

  rs_station_if #(.ROB_BIT(ROB_BIT), .OP_WIDTH(OP_WIDTH)) bus ();

  rs_station #(.RS_SIZE(RS_SIZE), .RS_BIT(4), .ROB_BIT(ROB_BIT), .OP_WIDTH(OP_WIDTH)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .flush_in(flush_in),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        busy;
    logic [5:0]  op;
    logic [31:0] vj, vk, imm;
    logic        qjb, qkb;
    logic [4:0]  qj, qk, rob;
  } ent_t;

  ent_t        m[RS_SIZE];
  logic        m_valid;
  logic [5:0]  m_op;
  logic [31:0] m_v1, m_v2, m_imm;
  logic [4:0]  m_rob;

  function automatic logic m_full();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // {hit, value} for a tag on the buses this cycle, ALU bus first
  function automatic logic [32:0] cdb_lookup(input logic [4:0] tag);
    if (bus.alu_cdb_valid && bus.alu_cdb_rob_id == tag) return {1'b1, bus.alu_cdb_value};
    if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_id == tag) return {1'b1, bus.lsb_cdb_value};
    return 33'd0;
  endfunction

  task automatic model_step();
    ent_t nx[RS_SIZE];
    ent_t e;
    int fi, ri;
    logic [32:0] hit;
    if (rst_in) begin
      foreach (m[i]) m[i] = '{default: '0};
      m_valid = 0; m_op = 0; m_v1 = 0; m_v2 = 0; m_imm = 0; m_rob = 0;
    end else if (!rdy_in) begin
      // frozen
    end else if (flush_in) begin
      foreach (m[i]) m[i].busy = 1'b0;
      m_valid = 1'b0;
    end else begin
      nx = m;
      fi = -1;
      ri = -1;
      foreach (m[i]) begin
        if (fi < 0 && !m[i].busy) fi = i;
        if (ri < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) ri = i;
      end
      m_valid = (ri >= 0);
      if (ri >= 0) begin
        m_op = m[ri].op; m_v1 = m[ri].vj; m_v2 = m[ri].vk;
        m_imm = m[ri].imm; m_rob = m[ri].rob;
        nx[ri].busy = 1'b0;
      end
      foreach (m[i]) begin
        if (m[i].busy && m[i].qjb) begin
          hit = cdb_lookup(m[i].qj);
          if (hit[32]) begin nx[i].vj = hit[31:0]; nx[i].qjb = 1'b0; end
        end
        if (m[i].busy && m[i].qkb) begin
          hit = cdb_lookup(m[i].qk);
          if (hit[32]) begin nx[i].vk = hit[31:0]; nx[i].qkb = 1'b0; end
        end
      end
      if (bus.issue_valid && fi >= 0) begin
        e.busy = 1'b1; e.op = bus.issue_op; e.imm = bus.issue_imm; e.rob = bus.issue_rob_id;
        e.vj = bus.issue_vj; e.vk = bus.issue_vk; e.qj = bus.issue_qj; e.qk = bus.issue_qk;
        e.qjb = bus.issue_qj_busy; e.qkb = bus.issue_qk_busy;
`ifdef RS_ISSUE_FWD_EN
        if (e.qjb) begin
          hit = cdb_lookup(e.qj);
          if (hit[32]) begin e.vj = hit[31:0]; e.qjb = 1'b0; end
        end
        if (e.qkb) begin
          hit = cdb_lookup(e.qk);
          if (hit[32]) begin e.vk = hit[31:0]; e.qkb = 1'b0; end
        end
`endif
        nx[fi] = e;
      end
      m = nx;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_full", 32'(bus.full), 32'(m_full()));
    check("model_alu_valid", 32'(bus.alu_valid), 32'(m_valid));
    check("model_alu_op", 32'(bus.alu_op), 32'(m_op));
    check("model_alu_v1", bus.alu_v1, m_v1);
    check("model_alu_v2", bus.alu_v2, m_v2);
    check("model_alu_imm", bus.alu_imm, m_imm);
    check("model_alu_rob_id", 32'(bus.alu_rob_id), 32'(m_rob));
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    model_step();
    check_model();
  endtask

  task automatic drv_idle();
    rst_in = 0; rdy_in = 1; flush_in = 0;
    bus.issue_valid = 0; bus.issue_op = 0; bus.issue_vj = 0; bus.issue_vk = 0; bus.issue_imm = 0;
    bus.issue_qj_busy = 0; bus.issue_qk_busy = 0; bus.issue_qj = 0; bus.issue_qk = 0;
    bus.issue_rob_id = 0;
    bus.alu_cdb_valid = 0; bus.alu_cdb_rob_id = 0; bus.alu_cdb_value = 0;
    bus.lsb_cdb_valid = 0; bus.lsb_cdb_rob_id = 0; bus.lsb_cdb_value = 0;
  endtask

  task automatic drv_issue(input logic [4:0] rob, input logic [31:0] vj, input logic [31:0] vk,
                           input logic qjb, input logic [4:0] qj, input logic qkb, input logic [4:0] qk);
    bus.issue_valid = 1; bus.issue_op = {1'b0, rob}; bus.issue_imm = 32'h100 + 32'(rob);
    bus.issue_rob_id = rob; bus.issue_vj = vj; bus.issue_vk = vk;
    bus.issue_qj_busy = qjb; bus.issue_qj = qj; bus.issue_qk_busy = qkb; bus.issue_qk = qk;
  endtask

  typedef struct {
    logic        iv;
    logic [4:0]  rob;
    logic [31:0] vj, vk;
    logic        qjb;
    logic [4:0]  qj;
    logic        acv;
    logic [4:0]  atag;
    logic [31:0] aval;
    logic        e_valid;
    logic [4:0]  e_rob;
    logic [31:0] e_v1, e_v2;
    logic        e_full;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 5'd3, 32'd5, 32'd7, 0, 5'd0, 0, 5'd0, 32'h0,  0, 5'd0, 32'd0,  32'd0, 0};
    tbl[1] = '{1, 5'd4, 32'd0, 32'd1, 1, 5'd9, 0, 5'd0, 32'h0,  1, 5'd3, 32'd5,  32'd7, 0};
    tbl[2] = '{0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 0, 5'd0, 32'h0,  0, 5'd3, 32'd5,  32'd7, 0};
    tbl[3] = '{0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 0, 5'd0, 32'h0,  0, 5'd3, 32'd5,  32'd7, 0};
    tbl[4] = '{0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 0, 5'd0, 32'h0,  0, 5'd3, 32'd5,  32'd7, 0};
    tbl[5] = '{0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 1, 5'd9, 32'h10, 0, 5'd3, 32'd5,  32'd7, 0};
    tbl[6] = '{0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 0, 5'd0, 32'h0,  1, 5'd4, 32'h10, 32'd1, 0};
    tbl[7] = '{0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 0, 5'd0, 32'h0,  0, 5'd4, 32'h10, 32'd1, 0};

    drv_idle();
    rst_in = 1;
    tick();
    check("reset_full", 32'(bus.full), 0);
    check("reset_alu_valid", 32'(bus.alu_valid), 0);
    check("reset_alu_op", 32'(bus.alu_op), 0);
    check("reset_alu_v1", bus.alu_v1, 0);
    check("reset_alu_v2", bus.alu_v2, 0);
    check("reset_alu_imm", bus.alu_imm, 0);
    check("reset_alu_rob_id", 32'(bus.alu_rob_id), 0);

    // basic dispatch latency and single wakeup
    foreach (tbl[i]) begin
      drv_idle();
      if (tbl[i].iv) drv_issue(tbl[i].rob, tbl[i].vj, tbl[i].vk, tbl[i].qjb, tbl[i].qj, 0, 5'd0);
      bus.alu_cdb_valid = tbl[i].acv; bus.alu_cdb_rob_id = tbl[i].atag; bus.alu_cdb_value = tbl[i].aval;
      tick();
      check($sformatf("tbl%0d_valid", i), 32'(bus.alu_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_rob", i), 32'(bus.alu_rob_id), 32'(tbl[i].e_rob));
      check($sformatf("tbl%0d_v1", i), bus.alu_v1, tbl[i].e_v1);
      check($sformatf("tbl%0d_v2", i), bus.alu_v2, tbl[i].e_v2);
      check($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].e_full));
    end

    // rdy_in low freezes everything, including the dispatch pulse
    drv_idle(); drv_issue(5'd2, 32'h22, 32'h23, 0, 5'd0, 0, 5'd0); tick();
    drv_idle(); rdy_in = 0; drv_issue(5'd3, 32'h33, 32'h34, 0, 5'd0, 0, 5'd0); tick();
    check("frz_valid_low", 32'(bus.alu_valid), 0);
    drv_idle(); tick();
    check("frz_dispatch", 32'(bus.alu_valid), 1);
    check("frz_dispatch_rob", 32'(bus.alu_rob_id), 2);
    drv_idle(); rdy_in = 0; tick();
    check("frz_valid_held", 32'(bus.alu_valid), 1);
    drv_idle(); tick();
    check("frz_valid_drop", 32'(bus.alu_valid), 0);
    check("frz_no_drop_issue", 32'(bus.alu_rob_id), 2);

    // entries 2 and 5 woken together: lower index first
    for (int i = 0; i < 6; i++) begin
      drv_idle();
      drv_issue(5'(10 + i), 32'h0, 32'(i), 1, (i == 2 || i == 5) ? 5'd7 : 5'd8, 0, 5'd0);
      tick();
    end
    drv_idle(); bus.alu_cdb_valid = 1; bus.alu_cdb_rob_id = 5'd7; bus.alu_cdb_value = 32'h77; tick();
    check("prio_wake_no_disp", 32'(bus.alu_valid), 0);
    drv_idle(); tick();
    check("prio_first_valid", 32'(bus.alu_valid), 1);
    check("prio_first_rob", 32'(bus.alu_rob_id), 12);
    check("prio_first_v1", bus.alu_v1, 32'h77);
    drv_idle(); tick();
    check("prio_second_valid", 32'(bus.alu_valid), 1);
    check("prio_second_rob", 32'(bus.alu_rob_id), 15);
    drv_idle(); tick();
    check("prio_after_valid", 32'(bus.alu_valid), 0);
    drv_idle(); flush_in = 1; tick();

    // fill, drop when full, drain one
    for (int i = 0; i < RS_SIZE; i++) begin
      drv_idle();
      drv_issue(5'(i), 32'h0, 32'h0, 1, (i == 0) ? 5'd30 : 5'd31, 0, 5'd0);
      tick();
      check($sformatf("fill%0d_full", i), 32'(bus.full), (i == RS_SIZE - 1) ? 32'd1 : 32'd0);
    end
    drv_idle(); drv_issue(5'd17, 32'h1, 32'h2, 0, 5'd0, 0, 5'd0); tick();
    check("full_drop_full", 32'(bus.full), 1);
    drv_idle(); tick();
    check("full_drop_no_disp", 32'(bus.alu_valid), 0);
    drv_idle(); bus.alu_cdb_valid = 1; bus.alu_cdb_rob_id = 5'd30; bus.alu_cdb_value = 32'hAA; tick();
    check("full_wake_full", 32'(bus.full), 1);
    drv_idle(); tick();
    check("full_disp_valid", 32'(bus.alu_valid), 1);
    check("full_disp_rob", 32'(bus.alu_rob_id), 0);
    check("full_disp_v1", bus.alu_v1, 32'hAA);
    check("full_disp_full", 32'(bus.full), 0);
    drv_idle(); flush_in = 1; tick();

    // flush with 8 busy entries and a concurrent ready issue and CDB
    for (int i = 0; i < 8; i++) begin
      drv_idle(); drv_issue(5'(20 + i), 32'h0, 32'h0, 1, 5'd31, 0, 5'd0); tick();
    end
    drv_idle(); flush_in = 1; drv_issue(5'd28, 32'h5, 32'h6, 0, 5'd0, 0, 5'd0);
    bus.alu_cdb_valid = 1; bus.alu_cdb_rob_id = 5'd31; bus.alu_cdb_value = 32'h31;
    tick();
    check("flush_valid", 32'(bus.alu_valid), 0);
    check("flush_full", 32'(bus.full), 0);
    drv_idle(); bus.alu_cdb_valid = 1; bus.alu_cdb_rob_id = 5'd31; tick();
    check("flush_no_issue", 32'(bus.alu_valid), 0);
    drv_idle(); tick();
    check("flush_no_stale", 32'(bus.alu_valid), 0);
    drv_idle(); drv_issue(5'd29, 32'h9, 32'h8, 0, 5'd0, 0, 5'd0); tick();
    drv_idle(); tick();
    check("post_flush_rob", 32'(bus.alu_rob_id), 29);
    check("post_flush_valid", 32'(bus.alu_valid), 1);

`ifdef RS_ISSUE_FWD_EN
    drv_idle(); drv_issue(5'd6, 32'h1, 32'hDEAD, 0, 5'd0, 1, 5'd6);
    bus.lsb_cdb_valid = 1; bus.lsb_cdb_rob_id = 5'd6; bus.lsb_cdb_value = 32'hAB;
    tick();
    drv_idle(); tick();
    check("fwd_valid", 32'(bus.alu_valid), 1);
    check("fwd_rob", 32'(bus.alu_rob_id), 6);
    check("fwd_v2", bus.alu_v2, 32'hAB);
`endif

    for (int n = 0; n < 3000; n++) begin
      drv_idle();
      rst_in   = ($urandom_range(0, 499) == 0);
      rdy_in   = ($urandom_range(0, 9) != 0);
      flush_in = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) < 6)
        drv_issue(5'($urandom_range(0, 31)), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) begin
        bus.alu_cdb_valid = 1; bus.alu_cdb_rob_id = 5'($urandom_range(0, 7)); bus.alu_cdb_value = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        bus.lsb_cdb_valid = 1; bus.lsb_cdb_rob_id = 5'($urandom_range(0, 7)); bus.lsb_cdb_value = $urandom;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rs_station.md
# rs_station

Reservation station for the ALU path of the out-of-order core. Accepts one decoded instruction per cycle from the issue stage into a free entry and tracks operand readiness by snooping the ALU and LSB common data buses. Each cycle it dispatches the lowest-indexed entry whose operands are both available to the ALU as a registered one-cycle pulse. Mispredict flush empties the station in one cycle.

## Interface
- RS_SIZE, 16: number of entries (power of two, ≥2)
- RS_BIT, 4: log2(RS_SIZE)
- ROB_BIT, 5: ROB tag width
- OP_WIDTH, 6: internal opcode width
- clk_in  in  1  clock; all state updates on rising edge
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global enable; low freezes all state and outputs
- flush_in  in  1  mispredict clear
- issue_valid  in  1  issue request this cycle
- issue_op  in  OP_WIDTH  opcode
- issue_vj, issue_vk, issue_imm  in  32 each  operand values, immediate
- issue_qj_busy, issue_qk_busy  in  1 each  operand not yet available
- issue_qj, issue_qk  in  ROB_BIT each  producer tags
- issue_rob_id  in  ROB_BIT  destination tag
- full  out  1  no free entry (combinational from busy bits)
- alu_cdb_valid, lsb_cdb_valid  in  1 each  broadcast valid
- alu_cdb_rob_id, lsb_cdb_rob_id  in  ROB_BIT each  broadcast tag
- alu_cdb_value, lsb_cdb_value  in  32 each  broadcast value
- alu_valid  out  1  dispatch pulse (registered)
- alu_op  out  OP_WIDTH; alu_v1, alu_v2, alu_imm  out  32 each; alu_rob_id  out  ROB_BIT

## Operation
- Entry state: busy, op, vj, vk, qj_busy, qj, qk_busy, qk, imm, rob_id. Entry prepared = busy & !qj_busy & !qk_busy.
- Free select: lowest-index entry with busy=0; full=1 iff all busy. Ready select: lowest-index prepared entry.
- Issue: if issue_valid & !full & !flush_in, write free-selected entry, busy←1. issue_valid while full: dropped, no state change (upstream must honour full).
- Wakeup: for every busy entry, qj_busy & qj==cdb tag on a valid bus → vj←value, qj_busy←0; same for k. Both buses match: ALU bus value taken.
- Dispatch: if any prepared entry, register its op/vj/vk/imm/rob_id to outputs, alu_valid←1, clear its busy at the same edge; else alu_valid←0 (data outputs hold).
- Issue and dispatch same cycle: independent entries (issue target not busy, dispatch target busy); both occur. full does not account for the same-cycle dispatch.
- Flush: all busy←0, alu_valid←0; simultaneous issue and CDB ignored.
- Reset: same as flush plus all data outputs and entry fields ←0. Priority rst_in > rdy_in low > flush_in > normal.

## Timing
- Reset values: full=0, alu_valid=0, alu_op/alu_v1/alu_v2/alu_imm/alu_rob_id=0.
- Issue of fully-ready instruction at edge E0 → alu_valid=1 after E1 (one-cycle latency minimum).
- CDB broadcast sampled at edge E0 completes last operand → dispatched after E1.
- Throughput one issue and one dispatch per cycle; alu_valid never high two cycles for the same rob_id.
- full reflects the entry written at E0 immediately after E0.
- rdy_in low: no register changes, including alu_valid.

## Configuration
- RS_ISSUE_FWD_EN defined: at issue, an operand whose issue_q*_busy=1 and tag matches a valid CDB in the same cycle is written as ready with the CDB value (ALU bus priority).
- Undefined: operands written exactly as presented; issue stage guarantees same-cycle CDB forwarding; same-cycle match is then lost (bench checks only with macro defined).

## Test plan
- Reset then issue ADD rob 3, vj=5, vk=7 both ready at E0 → alu_valid=1, v1=5, v2=7, rob_id=3 after E1; one pulse only.
- Issue rob 4 with qj=9 busy; 3 idle cycles → no dispatch; alu_cdb tag 9 value 0x10 → dispatch v1=0x10 next edge.
- Fill all 16 entries with unready ops → full=1; 17th issue dropped; one wakeup + dispatch → full=0 after dispatch edge.
- Entries 2 and 5 become ready same cycle → entry 2 dispatched first, entry 5 next cycle.
- 8 busy entries, flush_in with concurrent issue_valid → all busy cleared, alu_valid=0, full=0, no entry from the concurrent issue.
- With RS_ISSUE_FWD_EN: issue qk=6 busy while lsb_cdb tag 6 value 0xAB → dispatched next edge with v2=0xAB.
